text_lcd_multiline: RTL and testbench

TEXT_LCD_MULTILINE -- requirements
Module: text_lcd_multiline

---
 rtl/text_lcd_multiline_pkg.sv | 43 ++++
 rtl/text_lcd_multiline_char_rom.sv | 21 ++
 rtl/text_lcd_multiline.sv | 250 +++++++++++++++++++++++++
 tb/tb_text_lcd_multiline.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_lcd_multiline_pkg.sv
// Shared constants and state types for the multi-line character LCD driver.
// Cursor support is compiled in with TEXT_LCD_CURSOR_EN.
package text_lcd_multiline_pkg;

   localparam logic [7:0] CMD_FUNC_2L  = 8'h38;
   localparam logic [7:0] CMD_FUNC_1L  = 8'h30;
   localparam logic [7:0] CMD_DISP     = 8'h0C;
   localparam logic [7:0] CMD_DISP_CUR = 8'h0F;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE0    = 8'h80;
   localparam logic [7:0] CMD_LINE1    = 8'hC0;

   localparam logic [7:0] CH_A     = 8'h41;
   localparam logic [7:0] CH_DOT   = 8'h2E;
   localparam logic [7:0] CH_DASH  = 8'h2D;
   localparam logic [7:0] CH_SPACE = 8'h20;

   localparam int PWR_TICKS   = 15000;
   localparam int CLEAR_TICKS = 2000;
   localparam int WAIT_TICKS  = 40;
   localparam int E_TICKS     = 2;

   typedef enum logic [3:0] {
      S_PWR_WAIT,
      S_FUNC,
      S_DISP,
      S_CLEAR,
      S_ENTRY,
      S_IDLE,
      S_ADDR,
      S_CHAR,
      S_CURSOR,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      W_SETUP,
      W_EHIGH,
      W_WAIT
   } wphase_t;

endpackage

// File: rtl/text_lcd_multiline_char_rom.sv
// 5-bit character code to LCD ASCII byte; purely combinational.
// Part of text_lcd_multiline (optional TEXT_LCD_CURSOR_EN does not affect it).
module lcd_char_rom
   import text_lcd_multiline_pkg::*;
(
   input  logic [4:0] code,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = CH_SPACE;
      if (code < 5'd26) begin
         ascii = CH_A + {3'b000, code};
      end else if (code == 5'd26) begin
         ascii = CH_DOT;
      end else if (code == 5'd27) begin
         ascii = CH_DASH;
      end
   end

endmodule

// File: rtl/text_lcd_multiline.sv
// HD44780-style multi-line text LCD driver: init sequence plus snapshot refresh.
// Define TEXT_LCD_CURSOR_EN to add iCursorPos and a trailing cursor write.
module text_lcd_multiline
   import text_lcd_multiline_pkg::*;
#(
   parameter int TICK_DIV  = 50,
   parameter int NUM_COLS  = 16,
   parameter int NUM_LINES = 2
) (
   input  logic                             iCLK,
   input  logic                             iRST,
   input  logic [NUM_LINES*NUM_COLS*5-1:0]  iCharData,
   input  logic                             iUpdate,
`ifdef TEXT_LCD_CURSOR_EN
   input  logic [4:0]                       iCursorPos,
`endif
   output logic                             oBusy,
   output logic                             oDone,
   output logic [7:0]                       oLCD_D,
   output logic                             oLCD_E,
   output logic                             oLCD_RS,
   output logic                             oLCD_RW
);

   localparam int W = NUM_LINES * NUM_COLS * 5;
   localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
   localparam logic       LAST_LINE = 1'(NUM_LINES - 1);

   logic [15:0] div;
   logic        tick;

   state_t      state, state_n;
   wphase_t     phase, phase_n;
   logic [15:0] wcnt, wcnt_n;
   logic        e, e_n;
   logic        line, line_n;
   logic [3:0]  col, col_n;
   logic        pending, pending_n;
   logic [W-1:0] snap, snap_n;
`ifdef TEXT_LCD_CURSOR_EN
   logic [4:0]  cur, cur_n;
`endif

   logic        wr_state;
   logic        wr_end;
   logic        start;
   logic [15:0] wait_len;
   int          sel;
   logic [4:0]  code;
   logic [7:0]  ascii;
   logic [7:0]  lcd_d;
   logic        lcd_rs;

   assign tick = (div == 16'(TICK_DIV - 1));

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 16'd1;
      end
   end

   // Character for the current line/column, taken from the snapshot.
   assign sel = int'(line) * NUM_COLS + int'(col);

   always_comb begin
      code = '0;
      for (int i = 0; i < NUM_LINES * NUM_COLS; i++) begin
         if (i == sel) begin
            code = snap[i*5 +: 5];
         end
      end
   end

   lcd_char_rom u_rom (
      .code  (code),
      .ascii (ascii)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state   <= S_PWR_WAIT;
         phase   <= W_SETUP;
         wcnt    <= '0;
         e       <= 1'b0;
         line    <= 1'b0;
         col     <= '0;
         pending <= 1'b0;
         snap    <= '0;
`ifdef TEXT_LCD_CURSOR_EN
         cur     <= '0;
`endif
      end else begin
         state   <= state_n;
         phase   <= phase_n;
         wcnt    <= wcnt_n;
         e       <= e_n;
         line    <= line_n;
         col     <= col_n;
         pending <= pending_n;
         snap    <= snap_n;
`ifdef TEXT_LCD_CURSOR_EN
         cur     <= cur_n;
`endif
      end
   end

   assign wr_state = state inside {S_FUNC, S_DISP, S_CLEAR, S_ENTRY,
                                   S_ADDR, S_CHAR, S_CURSOR};
   assign wait_len = (state == S_CLEAR) ? 16'(CLEAR_TICKS)
                                        : 16'(WAIT_TICKS);

   always_comb begin
      state_n   = state;
      phase_n   = phase;
      wcnt_n    = wcnt;
      e_n       = e;
      line_n    = line;
      col_n     = col;
      pending_n = pending | iUpdate;
      snap_n    = snap;
`ifdef TEXT_LCD_CURSOR_EN
      cur_n     = cur;
`endif
      wr_end    = 1'b0;
      start     = 1'b0;

      // Bus write sequencer: setup, E high, then settle time.
      if (tick && wr_state) begin
         unique case (phase)
            W_SETUP: begin
               e_n     = 1'b1;
               phase_n = W_EHIGH;
               wcnt_n  = '0;
            end
            W_EHIGH: begin
               if (wcnt == 16'(E_TICKS - 1)) begin
                  e_n     = 1'b0;
                  phase_n = W_WAIT;
                  wcnt_n  = '0;
               end else begin
                  wcnt_n = wcnt + 16'd1;
               end
            end
            W_WAIT: begin
               if (wcnt == wait_len - 16'd1) begin
                  wr_end  = 1'b1;
                  phase_n = W_SETUP;
                  wcnt_n  = '0;
               end else begin
                  wcnt_n = wcnt + 16'd1;
               end
            end
            default: phase_n = W_SETUP;
         endcase
      end

      if (tick) begin
         unique case (state)
            S_PWR_WAIT: begin
               if (wcnt == 16'(PWR_TICKS - 1)) begin
                  state_n = S_FUNC;
                  wcnt_n  = '0;
               end else begin
                  wcnt_n = wcnt + 16'd1;
               end
            end
            S_FUNC:  if (wr_end) state_n = S_DISP;
            S_DISP:  if (wr_end) state_n = S_CLEAR;
            S_CLEAR: if (wr_end) state_n = S_ENTRY;
            S_ENTRY: if (wr_end) start = 1'b1;
            S_IDLE: begin
               if (pending || iUpdate) begin
                  start     = 1'b1;
                  pending_n = 1'b0;
               end
            end
            S_ADDR: begin
               if (wr_end) begin
                  state_n = S_CHAR;
                  col_n   = '0;
               end
            end
            S_CHAR: begin
               if (wr_end) begin
                  if (col != LAST_COL) begin
                     col_n = col + 4'd1;
                  end else if (line != LAST_LINE) begin
                     line_n  = 1'b1;
                     col_n   = '0;
                     state_n = S_ADDR;
                  end else begin
`ifdef TEXT_LCD_CURSOR_EN
                     state_n = S_CURSOR;
`else
                     state_n = S_DONE;
`endif
                  end
               end
            end
            S_CURSOR: if (wr_end) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_PWR_WAIT;
         endcase

         if (start) begin
            state_n = S_ADDR;
            line_n  = 1'b0;
            col_n   = '0;
            snap_n  = iCharData;
`ifdef TEXT_LCD_CURSOR_EN
            cur_n   = iCursorPos;
`endif
         end
      end
   end

   always_comb begin
      lcd_d  = '0;
      lcd_rs = 1'b0;
      unique case (state)
         S_FUNC:  lcd_d = (NUM_LINES == 2) ? CMD_FUNC_2L : CMD_FUNC_1L;
`ifdef TEXT_LCD_CURSOR_EN
         S_DISP:  lcd_d = CMD_DISP_CUR;
         S_CURSOR: lcd_d = CMD_LINE0 | {1'b0, cur[4], 2'b00, cur[3:0]};
`else
         S_DISP:  lcd_d = CMD_DISP;
`endif
         S_CLEAR: lcd_d = CMD_CLEAR;
         S_ENTRY: lcd_d = CMD_ENTRY;
         S_ADDR:  lcd_d = line ? CMD_LINE1 : CMD_LINE0;
         S_CHAR: begin
            lcd_d  = ascii;
            lcd_rs = 1'b1;
         end
         default: lcd_d = '0;
      endcase
   end

   assign oLCD_D  = lcd_d;
   assign oLCD_RS = lcd_rs;
   assign oLCD_E  = e;
   assign oLCD_RW = 1'b0;
   assign oBusy   = (state != S_IDLE);
   assign oDone   = (state == S_DONE) && tick;

endmodule

// File: tb/tb_text_lcd_multiline.sv
// Randomized bench for text_lcd_multiline with a bus-level reference model.
// Build with TEXT_LCD_CURSOR_EN to cover the cursor variant.
module tb_text_lcd_multiline;

   localparam int TD = 2;
   localparam int NC = 16;
   localparam int NL = 2;
   localparam int W  = NC * NL * 5;
`ifdef TEXT_LCD_CURSOR_EN
   localparam int RN = 2 + NC * NL + 1;
`else
   localparam int RN = 2 + NC * NL;
`endif

   typedef int codes_t[NL][NC];

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         upd = 1'b0;
   logic [W-1:0] data = '0;
   logic         busy, done, e, rs, rw;
   logic [7:0]   d;
`ifdef TEXT_LCD_CURSOR_EN
   logic [4:0]   cpos = 5'b1_0011;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int bus_q[$];
   int rise_q[$];
   codes_t codes;
   codes_t codes_a;

   text_lcd_multiline #(
      .TICK_DIV  (TD),
      .NUM_COLS  (NC),
      .NUM_LINES (NL)
   ) dut (
      .iCLK      (clk),
      .iRST      (rst),
      .iCharData (data),
      .iUpdate   (upd),
`ifdef TEXT_LCD_CURSOR_EN
      .iCursorPos(cpos),
`endif
      .oBusy     (busy),
      .oDone     (done),
      .oLCD_D    (d),
      .oLCD_E    (e),
      .oLCD_RS   (rs),
      .oLCD_RW   (rw)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: one entry per E rising edge, {rs, data}.
   logic prev_e = 1'b0;
   logic prev_done = 1'b0;
   int   held = 0;

   always @(negedge clk) begin
      if (e && !prev_e) begin
         bus_q.push_back(int'({rs, d}));
         rise_q.push_back(cyc);
         held <= int'({rs, d});
      end
      if (e && prev_e && !rst) check("bus_stable", int'({rs, d}), held);
      if (prev_done) check("done_width", int'(done), 0);
      if (done) done_cnt <= done_cnt + 1;
      prev_e    <= e;
      prev_done <= done;
   end

   function automatic logic [7:0] to_ascii(input int c);
      if (c < 26) return 8'(65 + c);
      if (c == 26) return 8'h2E;
      if (c == 27) return 8'h2D;
      return 8'h20;
   endfunction

   // Expected refresh: address, then each line's characters, optional cursor.
   task automatic check_refresh(input string tag, input int base,
                                input codes_t cd);
      int k;
      k = base;
      for (int l = 0; l < NL; l++) begin
         check($sformatf("%s_addr%0d", tag, l), bus_q[k],
               (l == 0) ? 32'h080 : 32'h0C0);
         k++;
         for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_ch%0d_%0d", tag, l, c), bus_q[k],
                  int'({1'b1, to_ascii(cd[l][c])}));
            k++;
         end
      end
`ifdef TEXT_LCD_CURSOR_EN
      check($sformatf("%s_cursor", tag), bus_q[k], 32'h0C3);
`endif
   endtask

   task automatic load_random();
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c < NC; c++) begin
            codes[l][c] = int'($urandom_range(0, 31));
         end
      end
   endtask

   task automatic drive_codes();
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c < NC; c++) begin
            data[(l*NC+c)*5 +: 5] = 5'(codes[l][c]);
         end
      end
   endtask

   task automatic pulse_update();
      @(posedge clk);
      #1 upd = 1'b1;
      @(posedge clk);
      #1 upd = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int target,
                            input int bound);
      int n;
      n = 0;
      while (done_cnt < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(done_cnt >= target), 1);
   endtask

   int r0, qb, db, n;

   initial begin
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c < NC; c++) codes[l][c] = 0;
      end

      repeat (3) @(negedge clk);
      check("rst_d", int'(d), 0);
      check("rst_e", int'(e), 0);
      check("rst_rs", int'(rs), 0);
      check("rst_rw", int'(rw), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_done", int'(done), 0);

      @(posedge clk);
      #1 rst = 1'b0;
      r0 = cyc;

      // Init sequence followed by automatic refresh of all-zero codes.
      wait_done("init_done", 1, 45000);
      check("init_count", int'(bus_q.size() >= 4 + RN), 1);
      check("cmd_func", bus_q[0], 32'h038);
`ifdef TEXT_LCD_CURSOR_EN
      check("cmd_disp", bus_q[1], 32'h00F);
`else
      check("cmd_disp", bus_q[1], 32'h00C);
`endif
      check("cmd_clear", bus_q[2], 32'h001);
      check("cmd_entry", bus_q[3], 32'h006);
      check("pwr_wait_cycles", rise_q[0] - r0, 15001 * TD);
      check("write_gap", rise_q[1] - rise_q[0], 43 * TD);
      check("clear_gap", rise_q[3] - rise_q[2], 2003 * TD);
      check_refresh("auto", 4, codes);
      repeat (4) @(negedge clk);
      check("auto_done_cnt", done_cnt, 1);
      check("idle_busy", int'(busy), 0);
      check("auto_len", bus_q.size(), 4 + RN);

      // Snapshot + request merging: data changes and 3 requests mid-refresh.
      qb = bus_q.size();
      db = done_cnt;
      load_random();
      drive_codes();
      codes_a = codes;
      pulse_update();
      repeat (600) @(negedge clk);
      check("refresh_busy", int'(busy), 1);
      load_random();
      drive_codes();
      for (int i = 0; i < 3; i++) begin
         pulse_update();
         repeat (50) @(negedge clk);
      end
      wait_done("merge_done", db + 2, 9000);
      repeat (4000) @(negedge clk);
      check("merge_done_cnt", done_cnt, db + 2);
      check("merge_len", bus_q.size(), qb + 2 * RN);
      check_refresh("snapA", qb, codes_a);
      check_refresh("snapB", qb + RN, codes);

      // Punctuation and blank codes.
      qb = bus_q.size();
      db = done_cnt;
      load_random();
      codes[0][0] = 26;
      codes[0][1] = 27;
      codes[1][0] = 28;
      codes[1][15] = 31;
      drive_codes();
      pulse_update();
      wait_done("punct_done", db + 1, 4000);
      repeat (4) @(negedge clk);
      check("punct_len", bus_q.size(), qb + RN);
      check_refresh("punct", qb, codes);

      // Reset while E is high.
      pulse_update();
      n = 0;
      while (!e && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("saw_e_high", int'(e), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_e", int'(e), 0);
      check("rst_mid_busy", int'(busy), 1);
      check("rst_mid_d", int'(d), 0);
      repeat (3) @(negedge clk);
      qb = bus_q.size();
      db = done_cnt;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3000) @(negedge clk);
      check("restart_quiet", bus_q.size(), qb);
      check("restart_busy", int'(busy), 1);
      check("restart_no_done", done_cnt, db);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
